// File: rtl/bus_dev_port.sv
// bus_dev_port: per-device port between one bus device and the bus arbiter.
//   TX queue: the device writes packets (tx_wr/tx_data). The arbiter sees
//   pndng/D_pop and drains the queue with pop.
//   RX queue: bus packets (push/D_push) addressed to dev_id or to broadcast
//   are buffered for the device (rx_rd/rx_data/rx_valid).
// Ports:
//   clk, reset (async, active low)
//   tx_wr, tx_data, tx_full            device-side TX
//   pndng, D_pop, pop                  arbiter-side TX
//   push, D_push                       bus-side RX
//   rx_rd, rx_data, rx_valid, rx_full  device-side RX
//   drop_cnt                           saturating count of lost packets

// bus_dev_port_fifo: circular FIFO with a registered show-ahead head.
// Ports: clk, reset, wr/wr_data (write), rd (consume head), head,
//        not_empty, full (registered flags), drop (write refused this cycle).
module bus_dev_port_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wr_data,
  input  logic             rd,
  output logic [width-1:0] head,
  output logic             not_empty,
  output logic             full,
  output logic             drop
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]    cnt, cnt_next;
  logic             wr_en, rd_en;
  logic [width-1:0] head_next;

  always_comb begin
    rd_en      = rd && (cnt != '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    wr_en      = wr && ((cnt != CW'(depth)) || rd_en);
    drop       = wr && !wr_en;
    rd_ptr_inc = rd_ptr + AW'(1);

    cnt_next = cnt;
    if (wr_en && !rd_en)      cnt_next = cnt + CW'(1);
    else if (!wr_en && rd_en) cnt_next = cnt - CW'(1);

    // The head register is loaded ahead of time so D_pop/rx_data never
    // depend combinationally on pop/rx_rd. When the only entry leaves while
    // a new one arrives, the incoming word becomes the head directly.
    head_next = head;
    if (cnt_next == '0)  head_next = '0;
    else if (rd_en)      head_next = (cnt == CW'(1)) ? wr_data : mem[rd_ptr_inc];
    else if (cnt == '0)  head_next = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      head      <= '0;
      not_empty <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr_inc;
      cnt       <= cnt_next;
      head      <= head_next;
      not_empty <= (cnt_next != '0);
      full      <= (cnt_next == CW'(depth));
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

module bus_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] dev_id    = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_full,
  output logic [7:0]         drop_cnt
);
  logic       tx_drop, rx_drop, rx_match, rx_wr;
  logic [8:0] drop_sum;

  bus_dev_port_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .wr        (tx_wr),
    .wr_data   (tx_data),
    .rd        (pop),
    .head      (D_pop),
    .not_empty (pndng),
    .full      (tx_full),
    .drop      (tx_drop)
  );

  // Packets for other devices are ignored outright and never count as drops.
  assign rx_match = (D_push[pckg_sz-1 -: 8] == dev_id) ||
                    (D_push[pckg_sz-1 -: 8] == broadcast);
  assign rx_wr    = push && rx_match;

  bus_dev_port_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .wr        (rx_wr),
    .wr_data   (D_push),
    .rd        (rx_rd),
    .head      (rx_data),
    .not_empty (rx_valid),
    .full      (rx_full),
    .drop      (rx_drop)
  );

  assign drop_sum = {1'b0, drop_cnt} + 9'(tx_drop) + 9'(rx_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt <= '0;
    else        drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end
endmodule

// File: tb/tb_bus_dev_port.sv
module tb_bus_dev_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_wr = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0;
  logic [15:0] tx_data = '0, D_push = '0;
  logic        tx_full, pndng, rx_valid, rx_full;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        wr;  logic [15:0] wd; logic pp;
    logic        ps;  logic [15:0] pd; logic rd;
    logic        e_pndng; logic [15:0] e_dpop; logic e_txfull;
    logic        e_rxv;   logic [15:0] e_rxd;  logic e_rxfull;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [15:0] wd, input logic pp,
                     input logic ps, input logic [15:0] pd, input logic rd,
                     input logic e_pndng, input logic [15:0] e_dpop, input logic e_txfull,
                     input logic e_rxv, input logic [15:0] e_rxd, input logic e_rxfull,
                     input logic [7:0] e_drop);
    vec_t v;
    v = '{wr, wd, pp, ps, pd, rd, e_pndng, e_dpop, e_txfull, e_rxv, e_rxd, e_rxfull, e_drop};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_pndng, input logic [15:0] e_dpop,
                         input logic e_txfull, input logic e_rxv, input logic [15:0] e_rxd,
                         input logic e_rxfull, input logic [7:0] e_drop);
    chk({tag, " pndng"},    32'(pndng),    32'(e_pndng));
    chk({tag, " D_pop"},    32'(D_pop),    32'(e_dpop));
    chk({tag, " tx_full"},  32'(tx_full),  32'(e_txfull));
    chk({tag, " rx_valid"}, 32'(rx_valid), 32'(e_rxv));
    chk({tag, " rx_data"},  32'(rx_data),  32'(e_rxd));
    chk({tag, " rx_full"},  32'(rx_full),  32'(e_rxfull));
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(e_drop));
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic wr, input logic [15:0] wd, input logic pp,
                       input logic ps, input logic [15:0] pd, input logic rd);
    tx_wr = wr; tx_data = wd; pop = pp; push = ps; D_push = pd; rx_rd = rd;
    @(posedge clk);
    #1;
    tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
  endtask

  initial begin
    // TX fill: 8 writes, 9th dropped.
    for (int i = 0; i < 8; i++)
      add(1, 16'(16'h0101 + i), 0, 0, '0, 0,  1, 16'h0101, (i == 7), 0, '0, 0, 8'd0);
    add(1, 16'h0109, 0, 0, '0, 0,  1, 16'h0101, 1, 0, '0, 0, 8'd1);
    // TX drain: head walks 0102..0108 then empties to 0.
    for (int k = 1; k <= 8; k++)
      add(0, '0, 1, 0, '0, 0,  (k < 8), (k < 8) ? 16'(16'h0101 + k) : 16'h0000, 0,
          0, '0, 0, 8'd1);
    add(0, '0, 1, 0, '0, 0,  0, 16'h0000, 0, 0, '0, 0, 8'd1);   // pop on empty ignored
    // RX filtering.
    add(0, '0, 0, 1, 16'h02AB, 0,  0, '0, 0, 1, 16'h02AB, 0, 8'd1);
    add(0, '0, 0, 1, 16'hFF33, 0,  0, '0, 0, 1, 16'h02AB, 0, 8'd1);
    add(0, '0, 0, 1, 16'h0511, 0,  0, '0, 0, 1, 16'h02AB, 0, 8'd1);
    add(0, '0, 0, 0, '0, 1,        0, '0, 0, 1, 16'hFF33, 0, 8'd1);
    add(0, '0, 0, 0, '0, 1,        0, '0, 0, 0, 16'h0000, 0, 8'd1);
    add(0, '0, 0, 0, '0, 1,        0, '0, 0, 0, 16'h0000, 0, 8'd1);  // rx_rd on empty

    // 1. Reset held with random inputs, then released.
    #3 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tx_wr = 1'($urandom); pop = 1'($urandom); push = 1'($urandom); rx_rd = 1'($urandom);
      tx_data = 16'($urandom); D_push = {8'h02, 8'($urandom)};
      @(posedge clk);
      #1;
      chk_all($sformatf("reset_hold%0d", c), 0, '0, 0, 0, '0, 0, 8'd0);
    end
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0; tx_data = '0; D_push = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset_release", 0, '0, 0, 0, '0, 0, 8'd0);

    // 2 and 4. Table vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].wd, vecs[i].pp, vecs[i].ps, vecs[i].pd, vecs[i].rd);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pndng, vecs[i].e_dpop, vecs[i].e_txfull,
              vecs[i].e_rxv, vecs[i].e_rxd, vecs[i].e_rxfull, vecs[i].e_drop);
    end

    // 3. TX wrap and simultaneous access (drop_cnt is 1 here).
    for (int i = 0; i < 5; i++) drive(1, 16'(16'h0201 + i), 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wrap_a D_pop%0d", i), 32'(D_pop), 32'(16'h0201 + i));
      drive(0, '0, 1, 0, '0, 0);
    end
    chk("wrap_a empty", 32'(pndng), 32'(0));
    for (int i = 0; i < 8; i++) drive(1, 16'(16'h0301 + i), 0, 0, '0, 0);
    chk("wrap_b tx_full", 32'(tx_full), 32'(1));
    chk("wrap_b head", 32'(D_pop), 32'(16'h0301));
    drive(1, 16'hAAAA, 1, 0, '0, 0);
    chk("full_wr_pop tx_full", 32'(tx_full), 32'(1));
    chk("full_wr_pop drop", 32'(drop_cnt), 32'(1));
    chk("full_wr_pop head", 32'(D_pop), 32'(16'h0302));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap_b D_pop%0d", i), 32'(D_pop), (i < 7) ? 32'(16'h0302 + i) : 32'h0000AAAA);
      drive(0, '0, 1, 0, '0, 0);
    end
    chk("wrap_b empty pndng", 32'(pndng), 32'(0));
    chk("wrap_b empty D_pop", 32'(D_pop), 32'(0));
    drive(1, 16'h5A5A, 1, 0, '0, 0);
    chk("empty_wr_pop pndng", 32'(pndng), 32'(1));
    chk("empty_wr_pop D_pop", 32'(D_pop), 32'(16'h5A5A));
    drive(0, '0, 1, 0, '0, 0);
    chk("empty_wr_pop drained", 32'(pndng), 32'(0));

    // 5. RX overflow.
    for (int i = 0; i < 9; i++) drive(0, '0, 0, 1, 16'(16'h0200 + i), 0);
    chk("rx_ovf rx_full", 32'(rx_full), 32'(1));
    chk("rx_ovf drop", 32'(drop_cnt), 32'(2));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rx_ovf rx_data%0d", i), 32'(rx_data), 32'(16'h0200 + i));
      drive(0, '0, 0, 0, '0, 1);
    end
    chk("rx_ovf empty rx_valid", 32'(rx_valid), 32'(0));
    chk("rx_ovf empty rx_data", 32'(rx_data), 32'(0));
    for (int i = 0; i < 8; i++) drive(0, '0, 0, 1, 16'(16'h0210 + i), 0);
    drive(0, '0, 0, 1, 16'h0218, 1);
    chk("rx_full_push_rd drop", 32'(drop_cnt), 32'(2));
    chk("rx_full_push_rd rx_full", 32'(rx_full), 32'(1));
    chk("rx_full_push_rd head", 32'(rx_data), 32'(16'h0211));
    for (int i = 0; i < 8; i++) drive(1, 16'(16'h0401 + i), 0, 0, '0, 0);
    drive(1, 16'h0409, 0, 1, 16'h0299, 0);
    chk("dual_drop", 32'(drop_cnt), 32'(4));
    for (int i = 0; i < 300; i++) begin
      drive(0, '0, 0, 1, 16'h02EE, 0);
      chk($sformatf("sat%0d", i), 32'(drop_cnt), (4 + i + 1 > 255) ? 32'd255 : 32'(4 + i + 1));
    end

    // 6. Async reset with both FIFOs half full.
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, '0, 1);
    chk("half D_pop", 32'(D_pop), 32'(16'h0405));
    chk("half rx_data", 32'(rx_data), 32'(16'h0215));
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", 0, '0, 0, 0, '0, 0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 16'h1234, 0, 0, '0, 0);
    chk_all("post_reset_tx", 1, 16'h1234, 0, 0, '0, 0, 8'd0);
    drive(0, '0, 0, 1, 16'h02CD, 0);
    chk("post_reset_rx rx_valid", 32'(rx_valid), 32'(1));
    chk("post_reset_rx rx_data", 32'(rx_data), 32'(16'h02CD));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
